// File: rtl/div32_seq.sv
// Sequential restoring divider: one quotient bit per clock, quotient on LO and
// remainder on HI. Signed mode divides magnitudes, then fixes signs in FIX.
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             BUSY,
    output logic             DONE,
    output logic             DBZ,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   r;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   dvs;
    logic [5:0]         cnt;
    logic               qsign;
    logic               rsign;
    logic               dbz_pend;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     r_sh;
    logic [WIDTH:0]     t;

    // The stored remainder is always below the divisor, so it fits in WIDTH
    // bits; only the shifted trial value needs the extra bit.
    always_comb begin
        a_abs = (SIGNED && A[WIDTH-1]) ? -A : A;
        b_abs = (SIGNED && B[WIDTH-1]) ? -B : B;
        r_sh  = {r, q[WIDTH-1]};
        t     = r_sh - {1'b0, dvs};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (START) state_nxt = (B == '0) ? FIX : RUN;
            RUN:  if (cnt == LAST_STEP) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign state_dbg = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r        <= '0;
            q        <= '0;
            dvs      <= '0;
            cnt      <= '0;
            qsign    <= 1'b0;
            rsign    <= 1'b0;
            dbz_pend <= 1'b0;
            HI       <= '0;
            LO       <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            DBZ      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: if (START) begin
                    BUSY     <= 1'b1;
                    r        <= '0;
                    cnt      <= '0;
                    dvs      <= b_abs;
                    dbz_pend <= (B == '0);
                    // On divide-by-zero q carries the raw dividend to HI.
                    q        <= (B == '0) ? A : a_abs;
                    qsign    <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
                    rsign    <= SIGNED & A[WIDTH-1];
                end
                RUN: begin
                    r   <= t[WIDTH] ? r_sh[WIDTH-1:0] : t[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], ~t[WIDTH]};
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    BUSY <= 1'b0;
                    DONE <= 1'b1;
                    if (dbz_pend) begin
                        LO  <= '1;
                        HI  <= q;
                        DBZ <= 1'b1;
                    end else begin
                        LO  <= qsign ? -q : q;
                        HI  <= rsign ? -r : r;
                        DBZ <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Directed bench for div32_seq: an arithmetic reference model plus a per-cycle
// compare process that tracks when each result is due.
module tb_div32_seq;

    localparam int EW = 65;  // {dbz, hi, lo}

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        SIGNED = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        BUSY;
    logic        DONE;
    logic        DBZ;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [EW-1:0] exp_q[$];
    int            due_q[$];
    logic [EW-1:0] last_res = '0;

    div32_seq #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .START(START), .SIGNED(SIGNED), .A(A), .B(B),
        .HI(HI), .LO(LO), .BUSY(BUSY), .DONE(DONE), .DBZ(DBZ),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb, qq, rr;
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        qq = sa / sb;
        rr = sa % sb;
        return {1'b0, rr[31:0], qq[31:0]};
    endfunction

    // ---------------- compare process ----------------
    always @(negedge CLK) begin
        logic exp_done;
        logic exp_busy;
        if (RST) begin
            checks++;
            if ({HI, LO, BUSY, DONE, DBZ} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got hi=%h lo=%h busy=%b done=%b dbz=%b required all 0",
                         HI, LO, BUSY, DONE, DBZ);
            end
            last_res = '0;
        end else begin
            if (due_q.size() > 0 && cyc > due_q[0]) begin
                errors++;
                $display("FAIL missed_done: cycle %0d required done at cycle %0d", cyc, due_q[0]);
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
            end
            exp_done = (due_q.size() > 0) && (due_q[0] == cyc);
            exp_busy = (due_q.size() > 0) && !exp_done;
            checks++;
            if ({BUSY, DONE} !== {exp_busy, exp_done}) begin
                errors++;
                $display("FAIL handshake: cycle %0d got busy=%b done=%b required busy=%b done=%b",
                         cyc, BUSY, DONE, exp_busy, exp_done);
            end
            if (exp_done) begin
                last_res = exp_q.pop_front();
                void'(due_q.pop_front());
            end
            checks++;
            if ({DBZ, HI, LO} !== last_res) begin
                errors++;
                $display("FAIL result: cycle %0d got dbz=%b hi=%h lo=%h required dbz=%b hi=%h lo=%h",
                         cyc, DBZ, HI, LO, last_res[64], last_res[63:32], last_res[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                            input logic [31:0] lo_l, input logic [31:0] hi_l, input logic dbz_l);
        logic [EW-1:0] lit;
        lit = {dbz_l, hi_l, lo_l};
        checks++;
        if (model(a, b, sgn) !== lit) begin
            errors++;
            $display("FAIL model_pin: a=%h b=%h s=%b got %h required %h", a, b, sgn,
                     model(a, b, sgn), lit);
        end
        @(posedge CLK);
        #1;
        A = a; B = b; SIGNED = sgn; START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        exp_q.push_back(lit);
        due_q.push_back(cyc + ((b == 32'd0) ? 1 : 33));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && due_q.size() > 0; i++) @(posedge CLK);
        if (due_q.size() > 0) begin
            errors++;
            $display("FAIL wait_idle: %0d results outstanding, required 0", due_q.size());
            exp_q.delete();
            due_q.delete();
        end
        repeat (2) @(posedge CLK);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [31:0] lo_l, input logic [31:0] hi_l, input logic dbz_l);
        start_op(a, b, sgn, lo_l, hi_l, dbz_l);
        wait_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge CLK);
        #2 RST = 1'b0;
        repeat (2) @(posedge CLK);

        do_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0);
        do_op(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        do_op(32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        do_op(32'd10, 32'd3, 1'b0, 32'd3, 32'd1, 1'b0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        do_op(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0);
        do_op(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        do_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0);
        do_op(32'hDEAD_BEEF, 32'h0001_0000, 1'b0, 32'h0000_DEAD, 32'h0000_BEEF, 1'b0);

        // START during a busy operation must be ignored.
        start_op(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0);
        repeat (9) @(posedge CLK);
        #1;
        A = 32'd1; B = 32'd0; SIGNED = 1'b1; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        wait_idle();

        // START held through the DONE cycle launches a second operation.
        @(posedge CLK);
        #1;
        A = 32'd100; B = 32'd7; SIGNED = 1'b0; START = 1'b1;
        @(posedge CLK);
        #1;
        exp_q.push_back({1'b0, 32'd2, 32'd14});
        due_q.push_back(cyc + 33);
        repeat (33) @(posedge CLK);
        #1;
        A = 32'd50; B = 32'd7;
        @(posedge CLK);
        #1;
        START = 1'b0;
        exp_q.push_back({1'b0, 32'd1, 32'd7});
        due_q.push_back(cyc + 33);
        wait_idle();

        // Asynchronous reset mid-RUN aborts the operation without a DONE.
        start_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        repeat (14) @(posedge CLK);
        #3;
        exp_q.delete();
        due_q.delete();
        RST = 1'b1;
        #1;
        checks++;
        if ({HI, LO, BUSY, DONE, DBZ} !== '0) begin
            errors++;
            $display("FAIL async_reset: got hi=%h lo=%h busy=%b done=%b dbz=%b required all 0",
                     HI, LO, BUSY, DONE, DBZ);
        end
        repeat (2) @(posedge CLK);
        #2 RST = 1'b0;
        repeat (40) @(posedge CLK);
        do_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
